// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide with a tag carried alongside; define MULDIV_FAST_MUL_EN for one-cycle multiplies.
// Latency N_BITS edges (1 edge for div special cases / fast mul); result held in DONE until out_ready, one op in flight.
module muldiv_unit #(
  parameter int N_BITS   = 32,
  parameter int TAG_BITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          op,
  input  logic [N_BITS-1:0]   in0,
  input  logic [N_BITS-1:0]   in1,
  input  logic [TAG_BITS-1:0] tag_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N_BITS-1:0]   out,
  output logic [TAG_BITS-1:0] tag_out
);

  localparam int W2    = 2 * N_BITS;
  localparam int CNT_W = $clog2(N_BITS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_BITS - 1);
  localparam logic [N_BITS-1:0] MIN_NEG  = {1'b1, {(N_BITS-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  typedef struct packed {
    logic is_div;
    logic hi_sel;
    logic rem_sel;
    logic neg;
  } ctrl_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [W2-1:0]      acc;
  logic [N_BITS-1:0]  opnd;
  ctrl_t              ctrl;

  logic               a_sgn, b_sgn, a_neg, b_neg;
  logic [N_BITS-1:0]  a_mag, b_mag;
  logic               div_zero, div_ovf;
  logic [N_BITS-1:0]  special_res;
  ctrl_t              ctrl_in;

  logic [N_BITS:0]    mul_sum;
  logic [W2-1:0]      mul_nxt;
  logic [N_BITS:0]    div_rem;
  logic [N_BITS+1:0]  div_diff;
  logic [W2-1:0]      div_nxt;
  logic [W2-1:0]      acc_nxt;
  logic [W2-1:0]      mul_fix;
  logic [N_BITS-1:0]  div_sel;
  logic [N_BITS-1:0]  calc_res;

  assign in_ready = (state == S_IDLE) && !rst;

  // Operand decode at acceptance: signedness, magnitudes and the result sign.
  always_comb begin
    a_sgn       = op[2] ? ~op[0] : (op != 3'b011);
    b_sgn       = op[2] ? ~op[0] : (op[2:1] == 2'b00);
    a_neg       = a_sgn & in0[N_BITS-1];
    b_neg       = b_sgn & in1[N_BITS-1];
    a_mag       = a_neg ? -in0 : in0;
    b_mag       = b_neg ? -in1 : in1;
    div_zero    = op[2] && (in1 == '0);
    div_ovf     = op[2] && !op[0] && (in0 == MIN_NEG) && (in1 == '1);
    special_res = '0;
    if (div_zero)
      special_res = op[1] ? in0 : '1;
    else if (div_ovf)
      special_res = op[1] ? '0 : MIN_NEG;
    ctrl_in.is_div  = op[2];
    ctrl_in.hi_sel  = (op[1:0] != 2'b00);
    ctrl_in.rem_sel = op[1];
    ctrl_in.neg     = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
  end

  // One iteration: shift-add multiply or restoring divide, then sign fixup.
  always_comb begin
    mul_sum  = {1'b0, acc[W2-1:N_BITS]} + {1'b0, opnd};
    mul_nxt  = acc[0] ? {mul_sum, acc[N_BITS-1:1]} : {1'b0, acc[W2-1:1]};
    // Partial remainder needs N_BITS+1 bits since the divisor may exceed 2^(N_BITS-1).
    div_rem  = acc[W2-1:N_BITS-1];
    div_diff = {1'b0, div_rem} - {2'b00, opnd};
    if (div_diff[N_BITS+1])
      div_nxt = {div_rem[N_BITS-1:0], acc[N_BITS-2:0], 1'b0};
    else
      div_nxt = {div_diff[N_BITS-1:0], acc[N_BITS-2:0], 1'b1};
    acc_nxt  = ctrl.is_div ? div_nxt : mul_nxt;
    mul_fix  = ctrl.neg ? -acc_nxt : acc_nxt;
    div_sel  = ctrl.rem_sel ? acc_nxt[W2-1:N_BITS] : acc_nxt[N_BITS-1:0];
    if (ctrl.is_div)
      calc_res = ctrl.neg ? -div_sel : div_sel;
    else
      calc_res = ctrl.hi_sel ? mul_fix[W2-1:N_BITS] : mul_fix[N_BITS-1:0];
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [W2-1:0]     a_ext, b_ext, fast_prod;
  logic [N_BITS-1:0] fast_res;

  always_comb begin
    a_ext     = {{N_BITS{a_neg}}, in0};
    b_ext     = {{N_BITS{b_neg}}, in1};
    fast_prod = a_ext * b_ext;
    fast_res  = ctrl_in.hi_sel ? fast_prod[W2-1:N_BITS] : fast_prod[N_BITS-1:0];
  end
`endif

  // Short paths enter DONE with out_valid low; it rises on the following edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      acc       <= '0;
      opnd      <= '0;
      ctrl      <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      tag_out   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            tag_out <= tag_in;
            ctrl    <= ctrl_in;
            cnt     <= '0;
            if (div_zero || div_ovf) begin
              out   <= special_res;
              state <= S_DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!op[2]) begin
              out   <= fast_res;
              state <= S_DONE;
            end
`endif
            else begin
              acc   <= {{N_BITS{1'b0}}, (op[2] ? a_mag : b_mag)};
              opnd  <= op[2] ? b_mag : a_mag;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc <= acc_nxt;
          if (cnt == CNT_LAST) begin
            cnt       <= '0;
            out       <= calc_res;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (N_BITS=32): directed RV32M cases, backpressure, mid-op reset and random ops against an arithmetic model.
module tb_muldiv_unit;

  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  op;
  logic [31:0] in0, in1, out;
  logic [4:0]  tag_in, tag_out;

  int n_assert = 0;
  int n_fail   = 0;

  muldiv_unit #(.N_BITS(32), .TAG_BITS(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .in0(in0), .in1(in1), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .tag_out(tag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", nm, obs, exp);
    end
  endtask

  // Reference: RV32M semantics via 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub, p;
    logic [63:0] up;
    sa = $signed(a);
    sb = $signed(b);
    ub = {32'h0, b};
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return MIN_NEG;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && (b == 0 || (!o[0] && a == MIN_NEG && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!o[2]) return 1;
`endif
    return 32;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return MIN_NEG;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tg);
    @(negedge clk);
    check("issue_in_ready", in_ready, 1);
    op = o; in0 = a; in1 = b; tag_in = tg; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tg, input logic [31:0] exp, input bit rel);
    int lat;
    issue(o, a, b, tg);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    check({nm, "_latency"}, lat, exp_lat(o, a, b));
    check({nm, "_out"}, out, exp);
    check({nm, "_tag"}, tag_out, tg);
    if (rel) begin
      @(negedge clk) out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check({nm, "_released"}, out_valid, 0);
    end
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    logic [4:0]  rt;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'd0; in0 = '0; in1 = '0; tag_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_tag_out", tag_out, 0);
    check("rst_in_ready", in_ready, 0);
    @(negedge clk) rst = 1'b0;
    #1 check("idle_in_ready", in_ready, 1);

    run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFEB, 1);
    run_op("mulh_min", 3'd1, MIN_NEG, MIN_NEG, 5'd1, 32'h4000_0000, 1);
    run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 1);
    run_op("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'hFFFF_FFFF, 1);
    run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 1);
    run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF, 1);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd6, 32'd14, 1);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd7, 32'd2, 1);
    run_op("div_by0", 3'd4, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 1);
    run_op("rem_by0", 3'd6, 32'd5, 32'd0, 5'd10, 32'd5, 1);
    run_op("divu_by0", 3'd5, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF, 1);
    run_op("div_ovf", 3'd4, MIN_NEG, 32'hFFFF_FFFF, 5'd12, MIN_NEG, 1);
    run_op("rem_ovf", 3'd6, MIN_NEG, 32'hFFFF_FFFF, 5'd13, 32'd0, 1);
    run_op("divu_big", 3'd5, 32'hFFFF_FFFF, 32'h8000_0001, 5'd14, 32'd1, 1);

    // Backpressure: result held, nothing accepted while DONE.
    run_op("bp", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFEB, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = ~in_valid; op = 3'd5; in0 = $urandom; in1 = 32'd3; tag_in = 5'd21;
      @(posedge clk);
      #1;
      check($sformatf("bp%0d_out", k), out, 32'hFFFF_FFEB);
      check($sformatf("bp%0d_tag", k), tag_out, 9);
      check($sformatf("bp%0d_valid", k), out_valid, 1);
      check($sformatf("bp%0d_in_ready", k), in_ready, 0);
    end
    @(negedge clk) begin in_valid = 1'b0; out_ready = 1'b1; end
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1 check("bp_no_second_op", out_valid, 0);

    // Reset during CALC iteration 10.
    issue(3'd7, 32'hDEAD_BEEF, 32'h1234, 5'd17);
    repeat (10) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_out", out, 0);
    check("abort_tag", tag_out, 0);
    check("abort_in_ready_in_rst", in_ready, 0);
    @(negedge clk) rst = 1'b0;
    #1 check("abort_in_ready", in_ready, 1);
    repeat (40) @(posedge clk);
    #1 check("abort_no_result", out_valid, 0);
    run_op("post_abort_divu", 3'd5, 32'd100, 32'd7, 5'd19, 32'd14, 1);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      rt = 5'($urandom);
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, rt, model(ro, ra, rb), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
